// File: rtl/pri_capture_pkg.sv
// Shared types for the priority-code capture block: code width, active-low idle code,
// FIFO occupancy states and the active-low to true-binary conversion.
package pri_capture_pkg;

    localparam int CODE_W = 3;

    typedef logic [CODE_W-1:0] code_t;

    // Encoder output when no line is active (active-low zero).
    localparam code_t CODE_IDLE = 3'b111;

    typedef enum logic [1:0] {
        FIFO_EMPTY   = 2'd0,
        FIFO_PARTIAL = 2'd1,
        FIFO_FULL    = 2'd2
    } fifo_state_e;

    function automatic code_t to_binary(input code_t code);
        return ~code;
    endfunction

endpackage

// File: rtl/pri_capture_fifo.sv
// Small capture FIFO: DEPTH entries of W bits, wrap-around pointers, separate occupancy count.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module pri_capture_fifo
    import pri_capture_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = CODE_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wr_data,
    output logic [W-1:0]     rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             dropped
);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    fifo_state_e      state;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        state = FIFO_PARTIAL;
        if (count_q == '0) begin
            state = FIFO_EMPTY;
        end else if (count_q == DEPTH_CNT) begin
            state = FIFO_FULL;
        end
    end

    assign empty   = (state == FIFO_EMPTY);
    assign full    = (state == FIFO_FULL);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push & (~full | do_pop);
    assign dropped = push & ~do_push;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset so it maps onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Head is addressed by the registered read pointer; stale contents are masked when empty.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/pri_code_capture.sv
// Samples the 8-3 encoder's active-low code and request flag, turns each new highest-priority
// request into one FIFO entry (true binary) and presents it over valid/ready.
// Optional input synchroniser: define PRI_CAPTURE_SYNC_EN for SYNC_STAGES-deep sampling.
module pri_code_capture
    import pri_capture_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     iClk,
    input  logic                     iRst_n,
    input  logic [CODE_W-1:0]        iCode,
    input  logic                     iReq,
    output logic [CODE_W-1:0]        oData,
    output logic                     oValid,
    input  logic                     iReady,
    output logic [$clog2(DEPTH):0]   oCount,
    output logic                     oFull,
    output logic                     oOverflow,
    input  logic                     iClrOvf
);

`ifdef PRI_CAPTURE_SYNC_EN
    // Code and flag share one stage count so they stay aligned through the synchroniser.
    localparam int STAGES = SYNC_STAGES;
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
`else
    localparam int STAGES = 1;
`endif

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two of at least 2");
    end

    logic [STAGES-1:0] req_pipe_q;
    code_t             code_pipe_q [STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_sample
            logic  req_d;
            code_t code_d;
            if (gi == 0) begin : g_in
                assign req_d  = iReq;
                assign code_d = iCode;
            end else begin : g_chain
                assign req_d  = req_pipe_q[gi-1];
                assign code_d = code_pipe_q[gi-1];
            end
            always_ff @(posedge iClk or negedge iRst_n) begin
                if (!iRst_n) begin
                    req_pipe_q[gi]  <= 1'b0;
                    code_pipe_q[gi] <= '0;
                end else begin
                    req_pipe_q[gi]  <= req_d;
                    code_pipe_q[gi] <= code_d;
                end
            end
        end
    endgenerate

    logic  s_req;
    code_t s_code;
    logic  prev_req_q, prev_req_d;
    code_t prev_code_q, prev_code_d;
    logic  ovf_q, ovf_d;
    logic  event_hit;
    logic  fifo_pop;
    logic  fifo_full;
    logic  fifo_empty;
    logic  fifo_dropped;

    assign s_req  = req_pipe_q[STAGES-1];
    assign s_code = code_pipe_q[STAGES-1];

    // New request, or the active highest-priority line changed while the request is held.
    always_comb begin
        prev_req_d  = s_req;
        prev_code_d = s_code;
        event_hit   = s_req & (~prev_req_q | (s_code != prev_code_q));
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            prev_req_q  <= 1'b0;
            prev_code_q <= CODE_IDLE;
        end else begin
            prev_req_q  <= prev_req_d;
            prev_code_q <= prev_code_d;
        end
    end

    assign fifo_pop = oValid & iReady;

    pri_capture_fifo #(
        .DEPTH (DEPTH),
        .W     (CODE_W)
    ) u_fifo (
        .clk     (iClk),
        .rst_n   (iRst_n),
        .push    (event_hit),
        .pop     (fifo_pop),
        .wr_data (to_binary(s_code)),
        .rd_data (oData),
        .count   (oCount),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .dropped (fifo_dropped)
    );

    // A drop in the same cycle as a clear keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (fifo_dropped) begin
            ovf_d = 1'b1;
        end else if (iClrOvf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign oValid    = ~fifo_empty;
    assign oFull     = fifo_full;
    assign oOverflow = ovf_q;

endmodule

// File: tb/tb_pri_code_capture.sv
// Directed bench for pri_code_capture: reset, single event, priority change, overflow,
// full push+pop, clear-vs-set priority and asynchronous mid-operation reset.
module tb_pri_code_capture;

    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;
`ifdef PRI_CAPTURE_SYNC_EN
    localparam int LAT = SYNC_STAGES + 1;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] code;
    logic       req;
    logic [2:0] data;
    logic       valid;
    logic       ready;
    logic [2:0] count;
    logic       full;
    logic       ovf;
    logic       clr_ovf;

    int checks = 0;
    int errors = 0;

    pri_code_capture #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .iClk      (clk),
        .iRst_n    (rst_n),
        .iCode     (code),
        .iReq      (req),
        .oData     (data),
        .oValid    (valid),
        .iReady    (ready),
        .oCount    (count),
        .oFull     (full),
        .oOverflow (ovf),
        .iClrOvf   (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Advance n clock cycles, ending on a falling edge where outputs are sampled.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    int drain_exp [4] = '{5, 4, 3, 0};

    initial begin
        rst_n   = 1'b0;
        req     = 1'b1;
        code    = 3'b010;
        ready   = 1'b0;
        clr_ovf = 1'b0;
        @(negedge clk);
        tick(2);

        // Reset with a request held
        check_eq("rst_valid", int'(valid), 0);
        check_eq("rst_count", int'(count), 0);
        check_eq("rst_data",  int'(data),  0);
        check_eq("rst_full",  int'(full),  0);
        check_eq("rst_ovf",   int'(ovf),   0);
        rst_n = 1'b1;
        tick(LAT - 1);
        check_eq("rel_early_count", int'(count), 0);
        tick(1);
        check_eq("rel_valid", int'(valid), 1);
        check_eq("rel_data",  int'(data),  5);
        check_eq("rel_count", int'(count), 1);
        tick(5);
        check_eq("rel_hold_count", int'(count), 1);
        ready = 1'b1;
        tick(1);
        check_eq("rel_pop_count", int'(count), 0);
        tick(1);
        check_eq("pop_empty_count", int'(count), 0);
        check_eq("pop_empty_valid", int'(valid), 0);
        ready = 1'b0;
        req   = 1'b0;
        tick(3);

        // Single event
        req  = 1'b1;
        code = 3'b100;
        tick(LAT - 1);
        check_eq("single_early_valid", int'(valid), 0);
        tick(1);
        check_eq("single_valid", int'(valid), 1);
        check_eq("single_data",  int'(data),  3);
        check_eq("single_count", int'(count), 1);
        tick(10);
        check_eq("single_hold_count", int'(count), 1);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check_eq("single_pop_count", int'(count), 0);
        req = 1'b0;
        tick(3);

        // Priority change while held
        req  = 1'b1;
        code = 3'b110;
        tick(LAT + 1);
        check_eq("prio_first_count", int'(count), 1);
        check_eq("prio_first_data",  int'(data),  1);
        code = 3'b000;
        tick(LAT + 1);
        check_eq("prio_second_count", int'(count), 2);
        check_eq("prio_head_data",    int'(data),  1);
        ready = 1'b1;
        tick(1);
        check_eq("prio_pop1_data",  int'(data),  7);
        check_eq("prio_pop1_count", int'(count), 1);
        tick(1);
        check_eq("prio_pop2_valid", int'(valid), 0);
        check_eq("prio_pop2_count", int'(count), 0);
        ready = 1'b0;

        // Overflow: five distinct codes, four slots
        for (int i = 1; i <= 5; i++) begin
            code = 3'(i);
            tick(2);
        end
        tick(LAT);
        check_eq("ovf_full",  int'(full),  1);
        check_eq("ovf_count", int'(count), 4);
        check_eq("ovf_flag",  int'(ovf),   1);
        check_eq("ovf_head",  int'(data),  6);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        check_eq("ovf_clear", int'(ovf), 0);

        // Push and pop in the same cycle while full
        code = 3'b111;
        tick(LAT - 1);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check_eq("fullpp_count", int'(count), 4);
        check_eq("fullpp_ovf",   int'(ovf),   0);
        check_eq("fullpp_head",  int'(data),  5);

        // Drop and clear in the same cycle: set wins
        code = 3'b110;
        tick(LAT - 1);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        check_eq("setwins_ovf",   int'(ovf),   1);
        check_eq("setwins_count", int'(count), 4);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        check_eq("setwins_clear", int'(ovf), 0);

        // Drain: retained order with the new code at the tail
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("drain%0d_data", i), int'(data), drain_exp[i]);
            ready = 1'b1;
            tick(1);
            ready = 1'b0;
        end
        check_eq("drain_valid", int'(valid), 0);

        // Asynchronous reset with three entries held
        req = 1'b0;
        tick(3);
        req  = 1'b1;
        code = 3'b011;
        tick(2);
        code = 3'b101;
        tick(2);
        code = 3'b110;
        tick(2);
        check_eq("midrst_pre_count", int'(count), 3);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_count", int'(count), 0);
        check_eq("midrst_valid", int'(valid), 0);
        check_eq("midrst_data",  int'(data),  0);
        tick(1);
        rst_n = 1'b1;
        tick(LAT);
        check_eq("midrst_rel_count", int'(count), 1);
        check_eq("midrst_rel_data",  int'(data),  1);
        tick(5);
        check_eq("midrst_rel_hold", int'(count), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
